// File: rtl/alu_exec_ctrl.sv
// ---------------------------------------------------------------------------
// alu_exec_ctrl
//
// Execute-stage ALU with its own control decoder. The opcode and funct fields
// are decoded into a 4-bit ALU operation. The operation is applied to WIDTH-bit
// operands, and the result is registered. Single-cycle operations complete one
// clock after they are accepted. When the ALU_MUL_EN macro is defined, an
// iterative shift-add multiplier is compiled in. It takes WIDTH clocks per
// multiply.
//
// Optional feature macro: ALU_MUL_EN (undefined = no multiplier, ready tied 1)
//
// Handshake: an operation transfers on a rising edge where valid_in && ready.
// While ready is low, valid_in is ignored, and upstream must hold the
// operation. Results are not back-pressured. valid_out is a one-cycle pulse,
// and result/zero/alu_ctrl/illegal hold their values between pulses.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   valid_in   in   opcode/funct/a/b carry an operation
//   ready      out  operation can be accepted this cycle
//   opcode     in   [5:0] instruction opcode
//   funct      in   [5:0] R-type function field (ignored otherwise)
//   a, b       in   [WIDTH-1:0] operands
//   valid_out  out  one-cycle completion pulse
//   result     out  [WIDTH-1:0] registered result
//   zero       out  result == 0
//   alu_ctrl   out  [3:0] decoded operation of the completed instruction
//   illegal    out  completed instruction failed to decode (result = 0)
//   state_dbg  out  FSM state for observation: 0 = IDLE, 1 = MUL
// ---------------------------------------------------------------------------
module alu_exec_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             valid_out,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [3:0]       alu_ctrl,
    output logic             illegal,
    output logic             state_dbg
);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_SLT = 4'b0111;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
`endif

    logic [3:0]       dec_ctrl;
    logic             dec_illegal;
    logic [WIDTH-1:0] exec_result;
    logic             accept_single;   // single-cycle op (or illegal) accepted

    // ---------------------------------------------------------------
    // Decode. An illegal instruction reports alu_ctrl = 0000.
    // ---------------------------------------------------------------
    always_comb begin
        dec_ctrl    = 4'b0000;
        dec_illegal = 1'b1;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000: begin dec_ctrl = OP_ADD; dec_illegal = 1'b0; end
                    6'b100010: begin dec_ctrl = OP_SUB; dec_illegal = 1'b0; end
                    6'b100100: begin dec_ctrl = OP_AND; dec_illegal = 1'b0; end
                    6'b100101: begin dec_ctrl = OP_OR;  dec_illegal = 1'b0; end
                    6'b101010: begin dec_ctrl = OP_SLT; dec_illegal = 1'b0; end
`ifdef ALU_MUL_EN
                    6'b011000: begin dec_ctrl = OP_MUL; dec_illegal = 1'b0; end
`endif
                    default: ;
                endcase
            end
            6'b001000, 6'b110011, 6'b110001, 6'b110111: begin
                dec_ctrl    = OP_ADD;
                dec_illegal = 1'b0;
            end
            6'b000100: begin
                dec_ctrl    = OP_SUB;
                dec_illegal = 1'b0;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Single-cycle datapath. The illegal gate matters here because
    // an illegal op shares the 0000 code with AND. Without the gate,
    // an illegal op would return a & b instead of 0.
    // ---------------------------------------------------------------
    always_comb begin
        exec_result = '0;
        if (!dec_illegal) begin
            case (dec_ctrl)
                OP_ADD:  exec_result = a + b;
                OP_SUB:  exec_result = a - b;
                OP_AND:  exec_result = a & b;
                OP_OR:   exec_result = a | b;
                OP_SLT:  exec_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                default: exec_result = '0;
            endcase
        end
    end

`ifdef ALU_MUL_EN
    // ---------------------------------------------------------------
    // Control FSM and shift-add multiplier
    // ---------------------------------------------------------------
    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_step;
    logic             mul_start, mul_done;

    // Conditionally add the multiplicand for the current multiplier bit.
    assign acc_step  = acc + (mplier[0] ? mcand : '0);
    assign state_dbg = (state == S_MUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        ready         = 1'b0;
        accept_single = 1'b0;
        mul_start     = 1'b0;
        mul_done      = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (valid_in) begin
                    if (!dec_illegal && dec_ctrl == OP_MUL) begin
                        mul_start  = 1'b1;
                        state_next = S_MUL;
                    end else begin
                        accept_single = 1'b1;
                    end
                end
            end
            S_MUL: begin
                // The last iteration runs on the edge where count == WIDTH-1.
                if (count == LAST) begin
                    mul_done   = 1'b1;
                    state_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (mul_start) begin
            count  <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (state == S_MUL) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end
`else
    // No multi-cycle operations, so every op is accepted immediately.
    assign ready         = 1'b1;
    assign state_dbg     = 1'b0;
    assign accept_single = valid_in;
`endif

    // ---------------------------------------------------------------
    // Output registers. They hold until the next completion.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            alu_ctrl  <= 4'b0000;
            illegal   <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (accept_single) begin
                valid_out <= 1'b1;
                result    <= exec_result;
                zero      <= (exec_result == '0);
                alu_ctrl  <= dec_ctrl;
                illegal   <= dec_illegal;
            end
`ifdef ALU_MUL_EN
            else if (mul_done) begin
                valid_out <= 1'b1;
                result    <= acc_step;
                zero      <= (acc_step == '0);
                alu_ctrl  <= OP_MUL;
                illegal   <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Parametrised successor to the combinational ALU control decoder. It decodes opcode plus funct into a 4-bit ALU operation, executes that operation on WIDTH-bit operands, and registers the result. An optional iterative shift-add multiplier runs as a multi-cycle operation. The block sits in the execute stage between the decode registers and the writeback/branch logic, and reports back-pressure with a ready/valid handshake.

## Interface
- WIDTH, 32, operand and result width in bits (≥4).
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- valid_in  input  1  opcode, funct, a and b hold a valid operation.
- ready  output  1  block can accept an operation this cycle.
- opcode  input  6  instruction opcode.
- funct  input  6  R-type function field; ignored for every other opcode.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- valid_out  output  1  one-cycle pulse; result, zero, alu_ctrl and illegal are valid.
- result  output  WIDTH  registered ALU result.
- zero  output  1  result == 0.
- alu_ctrl  output  4  decoded operation of the completed instruction.
- illegal  output  1  the completed instruction did not decode; result is 0.

## Operation
- Operation codes: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt (signed), 1000 mul.
- Decode for opcode 000000 (R-type), by funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or.
  - 101010 slt.
  - 011000 mul.
  - Any other funct is illegal.
- Decode for other opcodes:
  - 001000 (addi), 110011 (jalr), 110001 (auipc) and 110111 (lui) decode to add.
  - 000100 (beq) decodes to sub.
  - Any other opcode is illegal, with alu_ctrl reported as 0000.
- Arithmetic: add and sub wrap modulo 2^WIDTH. slt gives 1 or 0, zero-extended. mul keeps the low WIDTH bits of the unsigned product.
- Illegal operations complete like single-cycle ops: result = 0, zero = 1, illegal = 1.
- FSM states:
  - IDLE: ready = 1. On valid_in && ready, decode. A mul goes to MUL with count = 0. Every other op stays in IDLE and its result is registered.
  - MUL: ready = 0. Each cycle, if multiplier bit[0] = 1 then acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++. When count reaches WIDTH−1, register acc into result, pulse valid_out and return to IDLE.
- valid_in is ignored while ready = 0. The upstream stage must hold its operation until it sees ready.
- There is no output back-pressure. valid_out is a single-cycle pulse.
- Reset, asynchronous, including in the middle of a multiply:
  - state goes to IDLE and count clears;
  - ready = 1 and valid_out = 0;
  - result = 0, zero = 1, alu_ctrl = 0000, illegal = 0.

## Timing
- Single-cycle ops:
  - Accepted at edge E0; valid_out is high for the cycle after E0.
  - Throughput is one op per clock; back-to-back acceptance is allowed.
- mul:
  - Accepted at E0; iterations run on edges E1..E_WIDTH.
  - valid_out is high for the cycle after E_WIDTH, so latency is WIDTH clocks.
  - ready is low from after E0 until after E_WIDTH.
  - During the valid_out cycle, ready = 1 and a new op may be accepted.
- Outputs hold between valid_out pulses. Only valid_out returns to 0.

## Configuration
- ALU_MUL_EN defined: the mul decode, the MUL state, the counter and the shift-add datapath are compiled in.
- ALU_MUL_EN undefined:
  - funct 011000 decodes as illegal;
  - the FSM has no MUL state and ready is tied to 1;
  - the block is purely single-cycle with latency 1.

## Test plan
- Reset, then add with WIDTH=32, opcode 000000, funct 100000, a=5, b=7 → next cycle valid_out=1, result=12, alu_ctrl=0010, zero=0.
- beq, opcode 000100, a=b=0x1234 → result=0, zero=1, alu_ctrl=0110. Then slt with a=0xFFFFFFFF, b=1 → result=1.
- mul with ALU_MUL_EN, a=0xFFFF, b=0x10001:
  - ready=0 for 32 cycles;
  - valid_out 32 cycles after accept, result=0xFFFFFFFF;
  - valid_in pulses applied while busy are ignored.
- Opcode 111111 → illegal=1, result=0, zero=1, alu_ctrl=0000. Without ALU_MUL_EN, funct 011000 gives the same response with a latency of 1.
- rst_n low 10 cycles into a mul → all outputs return to their reset values immediately and ready=1. After release, an add of a=1, b=1 returns 2.
- Back-to-back ops every cycle, add, or, and, sub with a=0xF0, b=0x3C → results 0x12C, 0xFC, 0x30, 0xB4 on consecutive cycles.
